// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/writeback/branch handshake between the pipeline and the hazard controller.
// The master side is the pipeline datapath; the slave side is pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             dec_valid;
   logic [4:0]       dec_rs1;
   logic [4:0]       dec_rs2;
   logic [4:0]       dec_rd;
   logic             dec_wr;
   logic             dec_is_load;
   logic             wb_valid;
   logic [4:0]       wb_rd;
   logic             br_taken;
   logic             mem_stall;
   logic             stall;
   logic             bubble;
   logic             flush;
   logic             issue;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_wr, dec_is_load,
      output wb_valid, wb_rd, br_taken, mem_stall,
      input  stall, bubble, flush, issue, stall_cnt
   );

   modport slave (
      input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_wr, dec_is_load,
      input  wb_valid, wb_rd, br_taken, mem_stall,
      output stall, bubble, flush, issue, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// In-order pipeline hazard controller: register scoreboard, RUN/STALL/FLUSH FSM, stall counter.
// Define HAZARD_FORWARD_EN when ALU results are forwarded, so only loads are tracked writes.
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input logic                     clk,
   input logic                     rst,
   pipeline_hazard_ctrl_if.slave   hz
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t           state;
   logic [2:0]       flush_ctr;
   logic [31:0]      pending;
   logic [31:0]      pending_nxt;
   logic [CNT_W-1:0] stall_cnt;

   logic rs1_hit;
   logic rs2_hit;
   logic rd_hit;
   logic hazard;
   logic in_flush;
   logic issue;
   logic stall;
   logic tracked_wr;

`ifdef HAZARD_FORWARD_EN
   assign tracked_wr = hz.dec_wr & hz.dec_is_load;
`else
   logic unused_is_load;
   assign unused_is_load = hz.dec_is_load;
   assign tracked_wr     = hz.dec_wr;
`endif

   // Index 0 is the hardwired zero register, so it never creates a dependency.
   always_comb begin
      rs1_hit  = (hz.dec_rs1 != 5'd0) && pending[hz.dec_rs1];
      rs2_hit  = (hz.dec_rs2 != 5'd0) && pending[hz.dec_rs2];
      rd_hit   = hz.dec_wr && (hz.dec_rd != 5'd0) && pending[hz.dec_rd];
      hazard   = hz.dec_valid && (rs1_hit || rs2_hit || rd_hit);
      in_flush = (state == FLUSH);
      issue    = !in_flush && hz.dec_valid && !hz.br_taken && !hz.mem_stall && !hazard;
      stall    = !in_flush && !hz.br_taken && (hz.mem_stall || hazard);
   end

   assign hz.issue     = issue;
   assign hz.stall     = stall;
   assign hz.bubble    = !issue;
   assign hz.flush     = hz.br_taken || in_flush;
   assign hz.stall_cnt = stall_cnt;

   // Clear before set so a write issuing in the same cycle as a retirement to that register stays pending.
   always_comb begin
      pending_nxt = pending;
      if (hz.wb_valid && (hz.wb_rd != 5'd0)) begin
         pending_nxt[hz.wb_rd] = 1'b0;
      end
      if (issue && tracked_wr && (hz.dec_rd != 5'd0)) begin
         pending_nxt[hz.dec_rd] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   // A taken branch outranks every stall source; once in FLUSH further branches are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         flush_ctr <= 3'd0;
      end else begin
         case (state)
            RUN, STALL: begin
               if (hz.br_taken) begin
                  state     <= FLUSH;
                  flush_ctr <= FLUSH_LOAD;
               end else if (hz.mem_stall || hazard) begin
                  state <= STALL;
               end else begin
                  state <= RUN;
               end
            end
            FLUSH: begin
               if (flush_ctr == 3'd0) begin
                  state <= RUN;
               end else begin
                  flush_ctr <= flush_ctr - 3'd1;
               end
            end
            default: begin
               state     <= RUN;
               flush_ctr <= 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= 32'd0;
         stall_cnt <= '0;
      end else begin
         pending <= pending_nxt;
         if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors queue expected outputs,
// a negedge monitor pops and compares them. Covers both HAZARD_FORWARD_EN builds.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 16;

   // Expected control word ordering: {stall, bubble, flush, issue}.
   localparam logic [3:0] C_IDLE  = 4'b0100;
   localparam logic [3:0] C_ISSUE = 4'b0001;
   localparam logic [3:0] C_STALL = 4'b1100;
   localparam logic [3:0] C_FLUSH = 4'b0110;

   typedef struct {
      string            name;
      logic [3:0]       ctrl;
      logic             chk_cnt;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_hazard_ctrl #(
      .FLUSH_CYCLES(2),
      .CNT_W       (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz (bus.slave)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the rising edge and queue what the outputs must be.
   task automatic apply_stimulus(input string name, input logic r, input logic v,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic wr, input logic ld, input logic wbv, input logic [4:0] wbrd,
                                 input logic br, input logic ms, input logic [3:0] ctrl,
                                 input logic chkc, input logic [CNT_W-1:0] cnt);
      exp_t e;
      @(posedge clk);
      #1;
      rst             = r;
      bus.dec_valid   = v;
      bus.dec_rs1     = rs1;
      bus.dec_rs2     = rs2;
      bus.dec_rd      = rd;
      bus.dec_wr      = wr;
      bus.dec_is_load = ld;
      bus.wb_valid    = wbv;
      bus.wb_rd       = wbrd;
      bus.br_taken    = br;
      bus.mem_stall   = ms;
      e.name    = name;
      e.ctrl    = ctrl;
      e.chk_cnt = chkc;
      e.cnt     = cnt;
      exp_q.push_back(e);
   endtask

   task automatic check_output(input exp_t e);
      logic [3:0] got;
      got = {bus.stall, bus.bubble, bus.flush, bus.issue};
      checks++;
      if (got !== e.ctrl) begin
         errors++;
         $display("[TB] FAIL %s ctrl{stall,bubble,flush,issue} got %b want %b", e.name, got, e.ctrl);
      end
      if (e.chk_cnt) begin
         checks++;
         if (bus.stall_cnt !== e.cnt) begin
            errors++;
            $display("[TB] FAIL %s stall_cnt got %0d want %0d", e.name, bus.stall_cnt, e.cnt);
         end
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         check_output(exp_q.pop_front());
      end
   end

   initial begin
      bus.dec_valid   = 1'b0;
      bus.dec_rs1     = 5'd0;
      bus.dec_rs2     = 5'd0;
      bus.dec_rd      = 5'd0;
      bus.dec_wr      = 1'b0;
      bus.dec_is_load = 1'b0;
      bus.wb_valid    = 1'b0;
      bus.wb_rd       = 5'd0;
      bus.br_taken    = 1'b0;
      bus.mem_stall   = 1'b0;

      //                name           rst v  rs1    rs2    rd     wr ld wbv wbrd  br ms  ctrl    chk cnt
      apply_stimulus("reset",        1, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_IDLE,  1, 0);

`ifdef HAZARD_FORWARD_EN
      apply_stimulus("alu_x5",       0, 1, 5'd0,  5'd0,  5'd5,  1, 0, 0, 5'd0,  0, 0,  C_ISSUE, 1, 0);
      apply_stimulus("fwd_rs1_x5",   0, 1, 5'd5,  5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_ISSUE, 1, 0);
      apply_stimulus("load_x5",      0, 1, 5'd0,  5'd0,  5'd5,  1, 1, 0, 5'd0,  0, 0,  C_ISSUE, 0, 0);
      apply_stimulus("ld_use_rs2",   0, 1, 5'd0,  5'd5,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_STALL, 1, 0);
      apply_stimulus("ld_use_wb",    0, 1, 5'd0,  5'd5,  5'd0,  0, 0, 1, 5'd5,  0, 0,  C_STALL, 1, 1);
      apply_stimulus("ld_use_go",    0, 1, 5'd0,  5'd5,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_ISSUE, 1, 2);
`else
      apply_stimulus("alu_x5",       0, 1, 5'd0,  5'd0,  5'd5,  1, 0, 0, 5'd0,  0, 0,  C_ISSUE, 1, 0);
      apply_stimulus("raw_rs1_x5",   0, 1, 5'd5,  5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_STALL, 1, 0);
      apply_stimulus("raw_wb_x5",    0, 1, 5'd5,  5'd0,  5'd0,  0, 0, 1, 5'd5,  0, 0,  C_STALL, 1, 1);
      apply_stimulus("raw_go",       0, 1, 5'd5,  5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_ISSUE, 1, 2);
`endif

      apply_stimulus("set_clr_x7",   0, 1, 5'd0,  5'd0,  5'd7,  1, 1, 1, 5'd7,  0, 0,  C_ISSUE, 1, 2);
      apply_stimulus("x7_pending",   0, 1, 5'd7,  5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_STALL, 1, 2);
      apply_stimulus("x7_wb",        0, 1, 5'd7,  5'd0,  5'd0,  0, 0, 1, 5'd7,  0, 0,  C_STALL, 1, 3);
      apply_stimulus("x7_go",        0, 1, 5'd7,  5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_ISSUE, 1, 4);
      apply_stimulus("write_x0",     0, 1, 5'd0,  5'd0,  5'd0,  1, 1, 0, 5'd0,  0, 0,  C_ISSUE, 0, 0);
      apply_stimulus("read_x0",      0, 1, 5'd0,  5'd0,  5'd0,  1, 0, 0, 5'd0,  0, 0,  C_ISSUE, 1, 4);

      // Branch resolves while a hazard and a memory stall are both present.
      apply_stimulus("load_x9",      0, 1, 5'd0,  5'd0,  5'd9,  1, 1, 0, 5'd0,  0, 0,  C_ISSUE, 0, 0);
      apply_stimulus("br_cycle0",    0, 1, 5'd9,  5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 1,  C_FLUSH, 1, 4);
      apply_stimulus("br_cycle1",    0, 1, 5'd9,  5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 1,  C_FLUSH, 1, 4);
      apply_stimulus("br_cycle2",    0, 1, 5'd9,  5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 1,  C_FLUSH, 1, 4);
      apply_stimulus("after_flush",  0, 1, 5'd0,  5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_ISSUE, 1, 4);

      // Asynchronous reset in the middle of a flush, x9 still pending.
      apply_stimulus("br_again",     0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0,  C_FLUSH, 1, 4);
      apply_stimulus("rst_in_flush", 1, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_IDLE,  1, 0);
      apply_stimulus("x9_cleared",   0, 1, 5'd9,  5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0,  C_ISSUE, 1, 0);

      for (int i = 0; i < 70000; i++) begin
         apply_stimulus("mem_stall_run", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, C_STALL,
                        (i < 2) || (i >= 65533 && i <= 65537) || (i == 69999),
                        (i > 65535) ? 16'hFFFF : 16'(i));
      end
      apply_stimulus("cnt_saturated", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_IDLE, 1, 16'hFFFF);

      for (int w = 0; w < 10 && exp_q.size() != 0; w++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain pending got %0d want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
